// File: rtl/csi_2_phy_rx_data_lane.sv
// D-PHY data-lane receiver: LP entry tracking, 0xB8 leader hunt, byte alignment.
// Optional macro CSI_2_RX_SYNC_TOL_EN accepts a leader one bit away from 0xB8 as a soft error.
module csi_2_phy_rx_data_lane #(
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_TIMEOUT  = 64
) (
  input  logic       SysClk,
  input  logic       Reset,
  input  logic       RxClkActiveHs,
  input  logic       HsBit,
  input  logic       HsBitValid,
  input  logic       LpDp,
  input  logic       LpDn,
  output logic [7:0] RxByteHS,
  output logic       RxValidHS,
  output logic       RxActiveHS,
  output logic       RxSyncHS,
  output logic       ErrSotSyncHS,
  output logic       ErrControl,
  output logic       Stopstate,
  output logic [2:0] o_dbg_state
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam int TO_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int CNT_W = (TO_W > 3) ? TO_W : 3;
  localparam logic [SET_W-1:0] SET_MAX = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(SYNC_TIMEOUT - 1);
  localparam logic [7:0] LEADER = 8'hB8;

  typedef enum logic [2:0] {
    ST_STOP, ST_HS_RQST, ST_HS_SETTLE, ST_HS_SYNC, ST_HS_RX, ST_HS_WAIT
  } state_t;

  state_t           r_state, w_next;
  logic             r_dp_meta, r_dp_sync, r_dn_meta, r_dn_sync;
  logic [1:0]       w_lp;
  logic [SET_W-1:0] r_settle, w_settle;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_shift, w_shift, w_shift_in, r_byte, w_byte;
  logic             w_valid, w_sync, w_sot_err, w_ctrl_err, w_match, w_exact;
  logic             r_valid, r_sync, r_sot_err, r_ctrl_err, r_active, r_stop;

  // LP levels are asynchronous; idle lane (LP-11) is the safe reset value.
  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_dp_meta <= 1'b1;
      r_dp_sync <= 1'b1;
      r_dn_meta <= 1'b1;
      r_dn_sync <= 1'b1;
    end else begin
      r_dp_meta <= LpDp;
      r_dp_sync <= r_dp_meta;
      r_dn_meta <= LpDn;
      r_dn_sync <= r_dn_meta;
    end
  end

  assign w_lp       = {r_dp_sync, r_dn_sync};
  assign w_shift_in = {HsBit, r_shift[7:1]};
  assign w_exact    = (w_shift_in == LEADER);
`ifdef CSI_2_RX_SYNC_TOL_EN
  assign w_match    = ($countones(w_shift_in ^ LEADER) <= 1);
`else
  assign w_match    = w_exact;
`endif

  // HsBitValid qualifies HsBit for one cycle; there is no backpressure, so no ready.
  always_comb begin
    w_next     = r_state;
    w_settle   = r_settle;
    w_cnt      = r_cnt;
    w_shift    = r_shift;
    w_byte     = r_byte;
    w_valid    = 1'b0;
    w_sync     = 1'b0;
    w_sot_err  = 1'b0;
    w_ctrl_err = 1'b0;
    case (r_state)
      ST_STOP: begin
        if (w_lp == 2'b01) w_next = ST_HS_RQST;
      end
      ST_HS_RQST: begin
        if (w_lp == 2'b00) begin
          w_next   = ST_HS_SETTLE;
          w_settle = '0;
        end else if (w_lp == 2'b11) begin
          w_next = ST_STOP;
        end else if (w_lp == 2'b10) begin
          w_next     = ST_STOP;
          w_ctrl_err = 1'b1;
        end
      end
      ST_HS_SETTLE: begin
        if (w_lp == 2'b11) begin
          w_next = ST_STOP;
        end else if (r_settle == SET_MAX) begin
          if (RxClkActiveHs) begin
            w_next  = ST_HS_SYNC;
            w_shift = '0;
            w_cnt   = '0;
          end
        end else begin
          w_settle = r_settle + 1'b1;
        end
      end
      ST_HS_SYNC: begin
        if (w_lp == 2'b11) begin
          w_next = ST_STOP;
        end else if (!RxClkActiveHs) begin
          w_next = ST_HS_WAIT;
        end else if (HsBitValid) begin
          w_shift = w_shift_in;
          if (w_match) begin
            w_next    = ST_HS_RX;
            w_sync    = 1'b1;
            w_sot_err = ~w_exact;
            w_cnt     = '0;
          end else if (r_cnt == TO_LAST) begin
            w_next    = ST_HS_WAIT;
            w_sot_err = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_HS_RX: begin
        if (w_lp == 2'b11) begin
          w_next = ST_STOP;
        end else if (!RxClkActiveHs) begin
          w_next = ST_HS_WAIT;
        end else if (HsBitValid) begin
          w_shift = w_shift_in;
          if (r_cnt[2:0] == 3'd7) begin
            w_byte  = w_shift_in;
            w_valid = 1'b1;
            w_cnt   = '0;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      ST_HS_WAIT: begin
        if (w_lp == 2'b11) w_next = ST_STOP;
      end
      default: w_next = ST_STOP;
    endcase
  end

  always_ff @(posedge SysClk) begin
    if (Reset) begin
      r_state    <= ST_STOP;
      r_settle   <= '0;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_byte     <= '0;
      r_valid    <= 1'b0;
      r_sync     <= 1'b0;
      r_sot_err  <= 1'b0;
      r_ctrl_err <= 1'b0;
      r_active   <= 1'b0;
      r_stop     <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_settle   <= w_settle;
      r_cnt      <= w_cnt;
      r_shift    <= w_shift;
      r_byte     <= w_byte;
      r_valid    <= w_valid;
      r_sync     <= w_sync;
      r_sot_err  <= w_sot_err;
      r_ctrl_err <= w_ctrl_err;
      r_active   <= (w_next == ST_HS_RX);
      r_stop     <= (w_next == ST_STOP);
    end
  end

  assign RxByteHS     = r_byte;
  assign RxValidHS    = r_valid;
  assign RxActiveHS   = r_active;
  assign RxSyncHS     = r_sync;
  assign ErrSotSyncHS = r_sot_err;
  assign ErrControl   = r_ctrl_err;
  assign Stopstate    = r_stop;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_csi_2_phy_rx_data_lane.sv
// Directed-sequence bench with random payloads, scored against a bit-stream model of the lane.
module tb_csi_2_phy_rx_data_lane;
  localparam int SETTLE_CYCLES = 8;
  localparam int SYNC_TIMEOUT  = 64;

  logic       SysClk = 1'b0;
  logic       Reset, RxClkActiveHs, HsBit, HsBitValid, LpDp, LpDn;
  logic [7:0] RxByteHS;
  logic       RxValidHS, RxActiveHS, RxSyncHS, ErrSotSyncHS, ErrControl, Stopstate;
  logic [2:0] o_dbg_state;

  csi_2_phy_rx_data_lane #(.SETTLE_CYCLES(SETTLE_CYCLES), .SYNC_TIMEOUT(SYNC_TIMEOUT)) dut (
    .SysClk(SysClk), .Reset(Reset), .RxClkActiveHs(RxClkActiveHs), .HsBit(HsBit),
    .HsBitValid(HsBitValid), .LpDp(LpDp), .LpDn(LpDn), .RxByteHS(RxByteHS),
    .RxValidHS(RxValidHS), .RxActiveHS(RxActiveHS), .RxSyncHS(RxSyncHS),
    .ErrSotSyncHS(ErrSotSyncHS), .ErrControl(ErrControl), .Stopstate(Stopstate),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  always #5 SysClk = ~SysClk;

  int n_cmp = 0;
  int n_fail = 0;

  // output monitor: pulse counters and received bytes
  int         n_sync = 0, n_sot = 0, n_ctrl = 0, n_active = 0, got_n = 0;
  logic [7:0] got_mem [0:1023];
  always @(negedge SysClk) begin
    if (RxValidHS === 1'b1) begin
      got_mem[got_n] = RxByteHS;
      got_n = got_n + 1;
    end
    if (RxSyncHS === 1'b1) n_sync = n_sync + 1;
    if (ErrSotSyncHS === 1'b1) n_sot = n_sot + 1;
    if (ErrControl === 1'b1) n_ctrl = n_ctrl + 1;
    if (RxActiveHS === 1'b1) n_active = n_active + 1;
  end

  // scoreboard state
  bit         tx_bits[$];
  logic [7:0] exp_q[$];
  int         s_sync, s_sot, s_ctrl, s_active, s_got;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: last 8 bits of the stream (oldest in bit 0, zeros before the hunt)
  function automatic logic [7:0] window_at(input int i);
    logic [7:0] w;
    w = '0;
    for (int j = 0; j < 8; j++) begin
      if (i - 7 + j >= 0) w[j] = tx_bits[i - 7 + j];
    end
    return w;
  endfunction

  function automatic bit leader_ok(input logic [7:0] w);
`ifdef CSI_2_RX_SYNC_TOL_EN
    return $countones(w ^ 8'hB8) <= 1;
`else
    return w == 8'hB8;
`endif
  endfunction

  task automatic model(output int e_sync, output int e_sot);
    int s;
    logic [7:0] by;
    s = -1;
    e_sync = 0;
    e_sot = 0;
    exp_q.delete();
    for (int i = 0; i < tx_bits.size() && i < SYNC_TIMEOUT && s < 0; i++) begin
      if (leader_ok(window_at(i))) begin
        s = i;
        e_sync = 1;
        if (window_at(i) != 8'hB8) e_sot = 1;
      end
    end
    if (s < 0 && tx_bits.size() >= SYNC_TIMEOUT) e_sot = 1;
    if (s >= 0) begin
      for (int k = 0; s + 8 * (k + 1) < tx_bits.size(); k++) begin
        for (int j = 0; j < 8; j++) by[j] = tx_bits[s + 1 + 8 * k + j];
        exp_q.push_back(by);
      end
    end
  endtask

  // driver tasks
  task automatic lp_hold(input logic dp, input logic dn, input int n);
    LpDp = dp;
    LpDn = dn;
    repeat (n) @(posedge SysClk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit rec);
    repeat ($urandom_range(0, 1)) begin
      @(posedge SysClk);
      #1;
    end
    HsBit = b;
    HsBitValid = 1'b1;
    @(posedge SysClk);
    #1;
    HsBitValid = 1'b0;
    if (rec) tx_bits.push_back(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int j = 0; j < 8; j++) send_bit(v[j], 1'b1);
  endtask

  task automatic hs_entry();
    lp_hold(1'b1, 1'b1, 10);
    lp_hold(1'b0, 1'b1, 10);
    lp_hold(1'b0, 1'b0, 12);
    repeat ($urandom_range(0, 5)) send_bit(1'b0, 1'b1);
  endtask

  task automatic lp_exit(input string tag);
    LpDp = 1'b1;
    LpDn = 1'b1;
    repeat (2) @(posedge SysClk);
    @(negedge SysClk);
    chk({tag, " stop_early"}, 32'(Stopstate), 32'd0);
    @(negedge SysClk);
    chk({tag, " stop"}, 32'(Stopstate), 32'd1);
    chk({tag, " active_off"}, 32'(RxActiveHS), 32'd0);
    @(posedge SysClk);
    #1;
  endtask

  task automatic begin_pkt();
    tx_bits.delete();
    s_sync = n_sync;
    s_sot = n_sot;
    s_ctrl = n_ctrl;
    s_active = n_active;
    s_got = got_n;
  endtask

  task automatic check_packet(input string tag);
    int e_sync, e_sot, n_got;
    model(e_sync, e_sot);
    n_got = got_n - s_got;
    chk({tag, " sync_cnt"}, n_sync - s_sync, e_sync);
    chk({tag, " sot_cnt"}, n_sot - s_sot, e_sot);
    chk({tag, " ctrl_cnt"}, n_ctrl - s_ctrl, 0);
    chk({tag, " byte_cnt"}, n_got, exp_q.size());
    for (int k = 0; k < n_got && k < exp_q.size(); k++)
      chk({tag, " byte"}, 32'(got_mem[s_got + k]), 32'(exp_q[k]));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " byte"}, 32'(RxByteHS), 32'h00);
    chk({tag, " valid"}, 32'(RxValidHS), 32'd0);
    chk({tag, " active"}, 32'(RxActiveHS), 32'd0);
    chk({tag, " sync"}, 32'(RxSyncHS), 32'd0);
    chk({tag, " sot"}, 32'(ErrSotSyncHS), 32'd0);
    chk({tag, " ctrl"}, 32'(ErrControl), 32'd0);
    chk({tag, " stop"}, 32'(Stopstate), 32'd1);
  endtask

  initial begin
    logic [7:0] v, last;
    Reset = 1'b1;
    RxClkActiveHs = 1'b0;
    HsBit = 1'b0;
    HsBitValid = 1'b0;
    LpDp = 1'b1;
    LpDn = 1'b1;
    repeat (3) @(posedge SysClk);
    @(negedge SysClk);
    check_reset_values("reset");
    @(posedge SysClk);
    #1;
    Reset = 1'b0;
    RxClkActiveHs = 1'b1;

    // nominal packet: leader, 0x12, 0x34, random tail
    begin_pkt();
    hs_entry();
    send_byte(8'hB8);
    @(negedge SysClk);
    chk("nom sync_pulse", 32'(RxSyncHS), 32'd1);
    chk("nom active_on", 32'(RxActiveHS), 32'd1);
    send_byte(8'h12);
    @(negedge SysClk);
    chk("nom valid_12", 32'(RxValidHS), 32'd1);
    chk("nom byte_12", 32'(RxByteHS), 32'h12);
    @(negedge SysClk);
    chk("nom valid_one_cycle", 32'(RxValidHS), 32'd0);
    send_byte(8'h34);
    last = 8'h34;
    for (int k = 0; k < 4; k++) begin
      last = 8'($urandom);
      send_byte(last);
    end
    lp_exit("nom");
    chk("nom byte_hold", 32'(RxByteHS), 32'(last));
    check_packet("nom");

    // bad LP sequence 11 -> 01 -> 10
    begin_pkt();
    lp_hold(1'b1, 1'b1, 10);
    lp_hold(1'b0, 1'b1, 10);
    lp_hold(1'b1, 1'b0, 10);
    chk("badlp ctrl_cnt", n_ctrl - s_ctrl, 1);
    chk("badlp stop", 32'(Stopstate), 32'd1);
    chk("badlp active_cnt", n_active - s_active, 0);
    chk("badlp sync_cnt", n_sync - s_sync, 0);
    chk("badlp byte_cnt", got_n - s_got, 0);
    lp_hold(1'b1, 1'b1, 5);

    // sync timeout: 63 zeros are tolerated, the 64th expires the hunt
    begin_pkt();
    hs_entry();
    while (tx_bits.size() < SYNC_TIMEOUT - 1) send_bit(1'b0, 1'b1);
    chk("tmo sot_before_limit", n_sot - s_sot, 0);
    send_bit(1'b0, 1'b1);
    @(negedge SysClk);
    chk("tmo sot_pulse", 32'(ErrSotSyncHS), 32'd1);
    send_byte(8'hB8);
    lp_exit("tmo");
    chk("tmo active_cnt", n_active - s_active, 0);
    check_packet("tmo");

    // leader one bit away from 0xB8, then payload and zero fill past the timeout
    begin_pkt();
    hs_entry();
    send_byte(8'hB9);
    for (int k = 0; k < 2; k++) send_byte(8'($urandom));
    while (tx_bits.size() < SYNC_TIMEOUT + 8) send_bit(1'b0, 1'b1);
    lp_exit("tol");
    check_packet("tol");

    // LP-11 in the middle of a byte
    begin_pkt();
    hs_entry();
    send_byte(8'hB8);
    send_byte(8'($urandom));
    for (int k = 0; k < 4; k++) send_bit(1'($urandom), 1'b1);
    lp_exit("midexit");
    check_packet("midexit");

    // clock-lane loss mid-byte: later bits are ignored until LP-11
    begin_pkt();
    hs_entry();
    send_byte(8'hB8);
    send_byte(8'($urandom));
    for (int k = 0; k < 3; k++) send_bit(1'($urandom), 1'b1);
    RxClkActiveHs = 1'b0;
    @(posedge SysClk);
    @(negedge SysClk);
    chk("clkloss active_off", 32'(RxActiveHS), 32'd0);
    for (int k = 0; k < 16; k++) send_bit(1'($urandom), 1'b0);
    RxClkActiveHs = 1'b1;
    for (int k = 0; k < 16; k++) send_bit(1'($urandom), 1'b0);
    lp_exit("clkloss");
    check_packet("clkloss");

    // reset pulse in the middle of a byte
    begin_pkt();
    hs_entry();
    send_byte(8'hB8);
    v = 8'($urandom) | 8'h01;
    send_byte(v);
    for (int k = 0; k < 4; k++) send_bit(1'($urandom), 1'b1);
    Reset = 1'b1;
    @(posedge SysClk);
    #1;
    Reset = 1'b0;
    @(negedge SysClk);
    check_reset_values("midreset");
    for (int k = 0; k < 4; k++) send_bit(1'($urandom), 1'b0);
    lp_hold(1'b1, 1'b1, 5);
    check_packet("midreset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
